// File: rtl/spi_pkg.sv
// Shared constants and the state type for the SPI word-source stage.
package spi_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } former_state_t;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector with a synchronous active-high reset. A level that is
// already high when reset releases does not count as an edge until it has
// been seen low.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pulse
);

  logic r_q;
  // r_armed is set once the input has been observed low since reset.
  logic r_armed;

  // Track the previous level and whether a low has been seen since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= 1'b0;
      r_armed <= ~in;
    end else begin
      r_q     <= in;
      r_armed <= r_armed | ~in;
    end
  end

  assign pulse = in & ~r_q & r_armed;

endmodule

// File: rtl/spi_data_former.sv
// Word source for the SPI transmit path: counts next_count edges and offers a
// snapshot of the count on each start_send edge via a valid/ready handshake.
module spi_data_former
  import spi_pkg::*;
#(
  parameter int unsigned p_data_width = DATA_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic                    s_rst,
  input  logic                    next_count,
  input  logic                    start_send,
  input  logic                    ready,
  output logic                    valid,
  output logic [p_data_width-1:0] data
);

  logic                    w_rst;
  logic                    w_nc_rise;
  logic                    w_ss_rise;
  former_state_t           r_state;
  former_state_t           w_state_next;
  logic [p_data_width-1:0] r_cnt;
  logic [p_data_width-1:0] r_data;
  logic [p_data_width-1:0] w_data_next;

  assign w_rst = a_rst | s_rst;

  edge_rise u_nc_edge (
    .clk   (clk),
    .rst   (w_rst),
    .in    (next_count),
    .pulse (w_nc_rise)
  );

  edge_rise u_ss_edge (
    .clk   (clk),
    .rst   (w_rst),
    .in    (start_send),
    .pulse (w_ss_rise)
  );

  // Word counter: advances on every next_count edge regardless of state.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_cnt <= '0;
    end else if (w_nc_rise) begin
      r_cnt <= r_cnt + p_data_width'(1);
    end
  end

  // Next-state logic; start edges seen while SEND are dropped, not queued.
  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    unique case (r_state)
      IDLE: begin
        if (w_ss_rise) begin
          w_state_next = SEND;
          w_data_next  = r_cnt;
        end
      end
      SEND: begin
        if (ready) begin
          w_state_next = IDLE;
        end
      end
    endcase
  end

  // State and offered-word registers.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state <= IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
    end
  end

  assign valid = (r_state == SEND);
  assign data  = r_data;

endmodule

// File: tb/tb_spi_data_former.sv
// Self-checking bench for spi_data_former: directed table, hand sequences for
// wrap/collision, and a randomized run against an event-level reference model.
module tb_spi_data_former;

  localparam int unsigned W = 8;

  logic         clk;
  logic         a_rst;
  logic         s_rst;
  logic         next_count;
  logic         start_send;
  logic         ready;
  logic         valid;
  logic [W-1:0] data;

  spi_data_former #(
    .p_data_width (W)
  ) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .s_rst      (s_rst),
    .next_count (next_count),
    .start_send (start_send),
    .ready      (ready),
    .valid      (valid),
    .data       (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: number of counted events, the word on offer, and the
  // last level seen on each input (a reset cycle also counts as "seen").
  int m_cnt  = 0;
  bit m_off  = 1'b0;
  int m_data = 0;
  bit m_lss  = 1'b0;
  bit m_lnc  = 1'b0;

  typedef struct {
    bit ss;
    bit nc;
    bit rdy;
    bit ar;
    bit sr;
    bit ev;
    int ed;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit ss, bit nc, bit rdy, bit ar, bit sr, bit ev, int ed);
    vec_t v;
    v.ss = ss; v.nc = nc; v.rdy = rdy; v.ar = ar; v.sr = sr; v.ev = ev; v.ed = ed;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, update the model at the edge, sample after.
  task automatic cycle(input bit ss, input bit nc, input bit rdy, input bit ar, input bit sr);
    bit ncr;
    bit ssr;
    @(negedge clk);
    start_send = ss; next_count = nc; ready = rdy; a_rst = ar; s_rst = sr;
    @(posedge clk);
    if (ar || sr) begin
      m_cnt = 0; m_off = 1'b0; m_data = 0;
    end else begin
      ncr = nc && !m_lnc;
      ssr = ss && !m_lss;
      if (m_off) begin
        if (rdy) m_off = 1'b0;
      end else if (ssr) begin
        m_data = m_cnt;
        m_off  = 1'b1;
      end
      if (ncr) m_cnt = (m_cnt + 1) % (1 << W);
    end
    m_lss = ss;
    m_lnc = nc;
    #1;
    chk("model_valid", int'(valid), int'(m_off));
    chk("model_data", int'(data), m_data);
  endtask

  initial begin
    a_rst = 1'b1; s_rst = 1'b0; next_count = 1'b0; start_send = 1'b0; ready = 1'b0;

    // Reset via a_rst then s_rst.
    repeat (5) add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    repeat (5) add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // Four 2-cycle next_count pulses, then a 2-cycle start_send.
    for (int i = 0; i < 4; i++) begin
      add(0, 1, 0, 0, 0, 0, 0); add(0, 1, 0, 0, 0, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    end
    add(1, 0, 0, 0, 0, 1, 4); add(1, 0, 0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 1, 4); add(0, 0, 0, 0, 0, 1, 4);
    add(0, 0, 1, 0, 0, 0, 4); add(0, 0, 0, 0, 0, 0, 4);
    // Held offer with a next_count pulse in the window.
    add(1, 0, 0, 0, 0, 1, 4);
    add(0, 0, 0, 0, 0, 1, 4); add(0, 0, 0, 0, 0, 1, 4);
    add(0, 1, 0, 0, 0, 1, 4); add(0, 1, 0, 0, 0, 1, 4);
    repeat (5) add(0, 0, 0, 0, 0, 1, 4);
    add(0, 0, 1, 0, 0, 0, 4);
    add(1, 0, 0, 0, 0, 1, 5); add(0, 0, 1, 0, 0, 0, 5);
    // Ready pre-asserted: valid high for exactly one cycle.
    add(0, 0, 1, 0, 0, 0, 5); add(1, 0, 1, 0, 0, 1, 5);
    add(0, 0, 1, 0, 0, 0, 5); add(0, 0, 0, 0, 0, 0, 5);
    // Start edge during SEND is ignored.
    add(1, 0, 0, 0, 0, 1, 5); add(0, 0, 0, 0, 0, 1, 5);
    add(1, 0, 0, 0, 0, 1, 5); add(1, 0, 1, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 5); add(0, 0, 0, 0, 0, 0, 5);
    // Start edge in the handshake cycle is ignored too.
    add(1, 0, 0, 0, 0, 1, 5); add(0, 0, 0, 0, 0, 1, 5);
    add(1, 0, 1, 0, 0, 0, 5); add(0, 0, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 5);
    // s_rst mid-SEND drops the word.
    add(1, 0, 0, 0, 0, 1, 5); add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0);
    // start_send high across reset release is not an edge.
    add(1, 0, 0, 1, 0, 0, 0); add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0); add(0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 0); add(0, 0, 1, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      cycle(tbl[i].ss, tbl[i].nc, tbl[i].rdy, tbl[i].ar, tbl[i].sr);
      chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_data", i), int'(data), tbl[i].ed);
    end

    // Wrap: 256 counts return to 0.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
    end
    cycle(1, 0, 0, 0, 0);
    chk("wrap_valid", int'(valid), 1);
    chk("wrap_data", int'(data), 0);
    cycle(0, 0, 1, 0, 0);

    // Collision: start and count edges together at cnt=7.
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
    end
    cycle(1, 1, 0, 0, 0);
    chk("coll_data", int'(data), 7);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("coll_next_data", int'(data), 8);
    cycle(0, 0, 1, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
